aud_i2s_receiver: RTL and testbench
===================================

// Module: aud_i2s_receiver
// PURPOSE
//  I2S receiver for the WM8731 ADC path and the receive-side counterpart of the DAC-side I2S
//  player. Deserialises i_adcdat into 16-bit left/right samples, framed by i_adclrck.
//  Queues complete stereo frames in a small FIFO and offers them to the DSP/recorder over valid/ready.
//  Runs entirely in the codec bit-clock domain.
// PARAMETERS
//  DATA_W      16  bits per channel word; MSB first
//  FIFO_DEPTH   4  stereo frames buffered; power of 2, >=2
// PORTS
//  i_bclk         in   1        WM8731 bit clock; all logic on posedge
//  i_rst_n        in   1        synchronous, active-low reset
//  i_adclrck      in   1        WM8731 ADC LR clock; 0=left, 1=right
//  i_adcdat       in   1        WM8731 serial ADC data
//  i_en           in   1        capture enable; sampled only at left-channel start
//  i_clr_flags    in   1        clears o_overflow and o_frame_err
//  o_data_l       out  DATA_W   left sample of head frame
//  o_data_r       out  DATA_W   right sample of head frame
//  o_valid        out  1        head frame available
//  i_ready        in   1        consumer accepts head frame when o_valid&&i_ready
//  o_overflow     out  1        sticky: a complete frame was dropped because the FIFO was full
//  o_frame_err    out  1        sticky: an LRCK edge arrived before the current word completed
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge): state=S_IDLE, counters/FIFO pointers=0, lrck_q<=i_adclrck,
//   all outputs 0. Reset asserted mid-word or mid-frame discards that partial data.
//  Edge detect: lrck_q = i_adclrck registered each posedge. Fall = lrck_q&!i_adclrck, rise = !lrck_q&i_adclrck.
//  I2S timing: edge detected at posedge k -> MSB sampled at posedge k+1; bits at k+1..k+DATA_W.
//  FSM:
//   S_IDLE : fall && i_en -> S_REC_L, bit count=0, have_l=0. All other cases stay in S_IDLE.
//   S_REC_L: shift i_adcdat into sreg LSB each posedge and increment the count.
//            After DATA_W bits, latch the left word, set have_l=1, go to S_WAIT_R.
//   S_WAIT_R: rise -> S_REC_R, count=0. Fall -> frame_err, then handle as S_IDLE with fall.
//   S_REC_R: shift as in S_REC_L. After DATA_W bits, push {left,right} when have_l=1.
//            Then S_IDLE.
//   Any lrck edge in S_REC_L/S_REC_R before DATA_W bits: set o_frame_err, discard the partial frame.
//    A fall (with i_en) restarts in S_REC_L; otherwise go to S_IDLE.
//  i_en low during a frame: the frame in progress completes and is pushed; no new frame starts.
//  FIFO: push occurs on the posedge that samples the last right bit. o_valid and data are visible
//   the cycle after that push (1-cycle latency). Outputs reflect the head entry; pop = o_valid&&i_ready.
//   Full + push, no pop: frame dropped, o_overflow<=1, FIFO contents unchanged.
//   Full + push + pop in the same cycle: both take effect, no overflow.
//   Empty: o_valid=0, o_data_* hold their last value. Pointers wrap modulo FIFO_DEPTH.
//  i_clr_flags: clears both sticky flags; a set event in the same cycle wins (flag stays 1).
// TESTING
//  1. i_en=1, frame L=16'hA5C3, R=16'h0F0F, i_ready=1 -> o_valid pulses for 1 cycle.
//     That pulse occurs 1 bclk after the last R bit, with o_data_l=A5C3 and o_data_r=0F0F.
//  2. i_ready=0, send 5 frames (1..5), FIFO_DEPTH=4 -> frames 1-4 held, o_overflow=1.
//     Raise i_ready -> pops 1,2,3,4 in order, then o_valid=0.
//  3. FIFO full, push coincides with a pop -> no overflow, count stays 4, new frame at tail.
//  4. LRCK rises after 9 left bits -> o_frame_err=1, no push. The next clean frame is received correctly.
//  5. i_en falls mid-left word -> that frame is pushed. Next LRCK fall with i_en=0 -> no capture.
//  6. Reset pulsed during S_REC_R -> all outputs 0, FIFO empty. The next full frame is captured correctly.

Source files
------------

// File: rtl/aud_i2s_receiver.sv
// I2S receiver for the WM8731 ADC path: deserialises left/right words framed by LRCK
// and queues complete stereo frames in a small FIFO offered over valid/ready.
module aud_i2s_receiver #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_adclrck,
    input  logic              i_adcdat,
    input  logic              i_en,
    input  logic              i_clr_flags,
    output logic [DATA_W-1:0] o_data_l,
    output logic [DATA_W-1:0] o_data_r,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_overflow,
    output logic              o_frame_err
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_REC_L, S_WAIT_R, S_REC_R} state_t;

    state_t              state_q, state_d;
    logic                lrck_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   sreg_q, sreg_d;
    logic [DATA_W-1:0]   left_q, left_d;
    logic                have_l_q, have_l_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [DATA_W-1:0]   data_l_q, data_l_d, data_r_q, data_r_d;
    logic                overflow_q, overflow_d, frame_err_q, frame_err_d;
    logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic                fall, rise, last_bit, in_rec;
    logic                latch_l, push_req, err_evt, start_l;
    logic                full, pop, wr_en, ovf_set;
    logic [DATA_W-1:0]   word_w;
    logic [2*DATA_W-1:0] push_word, head_next;

    assign fall      = lrck_q & ~i_adclrck;
    assign rise      = ~lrck_q & i_adclrck;
    assign last_bit  = (cnt_q == LAST_CNT);
    assign in_rec    = (state_q == S_REC_L) || (state_q == S_REC_R);
    assign word_w    = {sreg_q[DATA_W-2:0], i_adcdat};
    assign push_word = {left_q, word_w};

    // State and datapath registers; reset is synchronous to the bit clock.
    always_ff @(posedge i_bclk) begin
        lrck_q <= i_adclrck;
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sreg_q      <= '0;
            left_q      <= '0;
            have_l_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            data_l_q    <= '0;
            data_r_q    <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sreg_q      <= sreg_d;
            left_q      <= left_d;
            have_l_q    <= have_l_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            data_l_q    <= data_l_d;
            data_r_q    <= data_r_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    // NOTE: FIFO storage is not reset; the occupancy count and the output hold registers are.
    always_ff @(posedge i_bclk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_word;
    end

    // A rise on the final left bit moves straight into the right word.
    always_comb begin
        // NOTE: default first so no path through this block infers a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (fall && i_en) state_d = S_REC_L;
            S_REC_L: begin
                if (last_bit)          state_d = rise ? S_REC_R : S_WAIT_R;
                else if (fall && i_en) state_d = S_REC_L;
                else if (fall || rise) state_d = S_IDLE;
            end
            S_WAIT_R: begin
                if (rise)      state_d = S_REC_R;
                else if (fall) state_d = i_en ? S_REC_L : S_IDLE;
            end
            S_REC_R: begin
                if (last_bit)          state_d = (fall && i_en) ? S_REC_L : S_IDLE;
                else if (fall && i_en) state_d = S_REC_L;
                else if (fall || rise) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        latch_l  = (state_q == S_REC_L) && last_bit;
        push_req = (state_q == S_REC_R) && last_bit && have_l_q;
        err_evt  = (in_rec && !last_bit && (fall || rise)) ||
                   ((state_q == S_WAIT_R) && fall);
        start_l  = (state_d == S_REC_L) && ((state_q != S_REC_L) || fall);
    end

    always_comb begin
        cnt_d    = (in_rec && (state_d == state_q) && !fall) ? cnt_q + CNT_W'(1) : '0;
        sreg_d   = in_rec ? word_w : sreg_q;
        left_d   = latch_l ? word_w : left_q;
        have_l_d = start_l ? 1'b0 : (latch_l ? 1'b1 : have_l_q);
    end

    assign full    = (occ_q == OCC_W'(FIFO_DEPTH));
    assign pop     = o_valid & i_ready;
    assign wr_en   = push_req & (~full | pop);
    assign ovf_set = push_req & full & ~pop;

    // Head of the next cycle is either the entry under rd_ptr_d or the word being written there now.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + AW'(wr_en);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        occ_d     = occ_q + OCC_W'(wr_en) - OCC_W'(pop);
        head_next = (wr_en && (wr_ptr_q == rd_ptr_d)) ? push_word : mem_q[rd_ptr_d];
        data_l_d  = data_l_q;
        data_r_d  = data_r_q;
        if (occ_d != '0) begin
            data_l_d = head_next[2*DATA_W-1:DATA_W];
            data_r_d = head_next[DATA_W-1:0];
        end
        overflow_d  = ovf_set | (overflow_q & ~i_clr_flags);
        frame_err_d = err_evt | (frame_err_q & ~i_clr_flags);
    end

    assign o_valid     = (occ_q != '0);
    assign o_data_l    = data_l_q;
    assign o_data_r    = data_r_q;
    assign o_overflow  = overflow_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_aud_i2s_receiver.sv
// Directed bench for aud_i2s_receiver: frames are driven bit by bit on the falling
// bclk edge and outputs are checked 1 time unit after the rising edge.
module tb_aud_i2s_receiver;

    logic        clk = 1'b0;
    logic        rst_n, adclrck, adcdat, en, clr_flags, ready;
    logic [15:0] data_l, data_r;
    logic        valid, overflow, frame_err;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    aud_i2s_receiver #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
        .i_bclk      (clk),
        .i_rst_n     (rst_n),
        .i_adclrck   (adclrck),
        .i_adcdat    (adcdat),
        .i_en        (en),
        .i_clr_flags (clr_flags),
        .o_data_l    (data_l),
        .o_data_r    (data_r),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_overflow  (overflow),
        .o_frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One bit slot: drive on the falling edge, return just after the sampling edge.
    task automatic slot(input logic lr, input logic d);
        @(negedge clk);
        adclrck = lr;
        adcdat  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic lr, input logic [15:0] word, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) slot(lr, word[i]);
    endtask

    // Full frame with 3 idle slots after the left word; returns right after the push edge.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic pop_last);
        slot(1'b0, 1'b0);
        send_bits(1'b0, l, 15, 0);
        repeat (3) slot(1'b0, 1'b0);
        slot(1'b1, 1'b0);
        send_bits(1'b1, r, 15, 1);
        if (pop_last) ready = 1'b1;
        slot(1'b1, r[0]);
        if (pop_last) ready = 1'b0;
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        slot(1'b1, 1'b0);
        clr_flags = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; adclrck = 1'b1; adcdat = 1'b0;
        en = 1'b0; clr_flags = 1'b0; ready = 1'b0;
        repeat (3) slot(1'b1, 1'b0);
        check("rst_valid", valid, 0);
        check("rst_data_l", data_l, 0);
        check("rst_data_r", data_r, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        slot(1'b1, 1'b0);

        // 1: single frame, consumer always ready -> one-cycle valid pulse
        en = 1'b1; ready = 1'b1;
        send_frame(16'hA5C3, 16'h0F0F, 1'b0);
        check("t1_valid", valid, 1);
        check("t1_data_l", data_l, 16'hA5C3);
        check("t1_data_r", data_r, 16'h0F0F);
        slot(1'b1, 1'b0);
        check("t1_valid_drop", valid, 0);
        check("t1_hold_l", data_l, 16'hA5C3);
        check("t1_hold_r", data_r, 16'h0F0F);
        ready = 1'b0;

        // 2: five frames into a four-deep FIFO, then drain
        for (int i = 1; i <= 5; i++) send_frame(16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b0);
        check("t2_overflow", overflow, 1);
        check("t2_valid", valid, 1);
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t2_pop_l", data_l, 32'h1000 + 32'(i));
            check("t2_pop_r", data_r, 32'h2000 + 32'(i));
            slot(1'b1, 1'b0);
        end
        check("t2_empty", valid, 0);
        check("t2_hold_l", data_l, 16'h1004);
        ready = 1'b0;
        check("t2_ovf_sticky", overflow, 1);
        clear_flags();
        check("t2_ovf_clr", overflow, 0);

        // 3: full FIFO, push coincides with pop
        for (int i = 6; i <= 9; i++) send_frame(16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b0);
        send_frame(16'h100A, 16'h200A, 1'b1);
        check("t3_no_ovf", overflow, 0);
        ready = 1'b1;
        for (int i = 7; i <= 10; i++) begin
            check("t3_valid", valid, 1);
            check("t3_pop_l", data_l, 32'h1000 + 32'(i));
            check("t3_pop_r", data_r, 32'h2000 + 32'(i));
            slot(1'b1, 1'b0);
        end
        check("t3_empty", valid, 0);
        ready = 1'b0;

        // 4: LRCK rises after 9 left bits; clear request in the same cycle loses
        slot(1'b0, 1'b0);
        repeat (9) slot(1'b0, 1'b1);
        clr_flags = 1'b1;
        slot(1'b1, 1'b0);
        clr_flags = 1'b0;
        check("t4_frame_err", frame_err, 1);
        repeat (20) slot(1'b1, 1'b0);
        check("t4_no_push", valid, 0);
        send_frame(16'hBEEF, 16'h1234, 1'b0);
        check("t4_valid", valid, 1);
        check("t4_data_l", data_l, 16'hBEEF);
        check("t4_data_r", data_r, 16'h1234);
        check("t4_err_sticky", frame_err, 1);
        ready = 1'b1;
        slot(1'b1, 1'b0);
        ready = 1'b0;
        clear_flags();
        check("t4_err_clr", frame_err, 0);

        // 5: enable drops mid-left word -> frame still completes; next frame ignored
        slot(1'b0, 1'b0);
        send_bits(1'b0, 16'hC0DE, 15, 8);
        en = 1'b0;
        send_bits(1'b0, 16'hC0DE, 7, 0);
        repeat (3) slot(1'b0, 1'b0);
        slot(1'b1, 1'b0);
        send_bits(1'b1, 16'h5A5A, 15, 0);
        check("t5_valid", valid, 1);
        check("t5_data_l", data_l, 16'hC0DE);
        check("t5_data_r", data_r, 16'h5A5A);
        ready = 1'b1;
        slot(1'b1, 1'b0);
        ready = 1'b0;
        send_frame(16'h1111, 16'h2222, 1'b0);
        slot(1'b1, 1'b0);
        check("t5_no_capture", valid, 0);
        check("t5_hold_l", data_l, 16'hC0DE);

        // 6: reset during the right word
        en = 1'b1;
        send_frame(16'h3333, 16'h4444, 1'b0);
        check("t6_pre_valid", valid, 1);
        slot(1'b0, 1'b0);
        send_bits(1'b0, 16'h7777, 15, 0);
        repeat (3) slot(1'b0, 1'b0);
        slot(1'b1, 1'b0);
        send_bits(1'b1, 16'hFFFF, 15, 11);
        rst_n = 1'b0;
        slot(1'b1, 1'b1);
        rst_n = 1'b1;
        check("t6_rst_valid", valid, 0);
        check("t6_rst_data_l", data_l, 0);
        check("t6_rst_data_r", data_r, 0);
        check("t6_rst_ovf", overflow, 0);
        check("t6_rst_err", frame_err, 0);
        repeat (12) slot(1'b1, 1'b1);
        check("t6_no_stale", valid, 0);
        send_frame(16'h9876, 16'h4321, 1'b0);
        check("t6_valid", valid, 1);
        check("t6_data_l", data_l, 16'h9876);
        check("t6_data_r", data_r, 16'h4321);
        check("t6_err_none", frame_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
